// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic REQ_A    = 1'b0;
   localparam logic REQ_B    = 1'b1;
   // B counts as the previous winner out of reset, so A takes the first tie
   localparam logic LAST_RST = REQ_B;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Combinational two-way picker; ROM_ARB_FIXED_PRIO_EN selects fixed A-first priority.
module rr_pick2
   import rom_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any
);

   assign any = |req;

`ifdef ROM_ARB_FIXED_PRIO_EN
   assign winner = req[1] & ~req[0];
`else
   // On a tie the requester that did not win last time goes next
   assign winner = req[1] & (~req[0] | (last == REQ_A));
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-address ROM between requesters A and B.
// Define ROM_ARB_FIXED_PRIO_EN for fixed A-first priority instead of round-robin.
//
// state | meaning
// IDLE  | no access in flight, ready to grant
// WAIT  | address presented to the ROM, counting down the read latency
// RESP  | read word delivered with valid; may grant again in the same cycle
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int ROM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   output logic [1:0]    gnt,
   output logic [1:0]    valid,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_q,
   output logic          busy
);

   localparam int CW = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    gnt_nxt, valid_nxt;
   logic [AW-1:0] rom_addr_nxt;
   logic [DW-1:0] rd_data_nxt;
   logic          owner, owner_nxt;
   logic          last;
   logic          winner, any;

   rr_pick2 u_pick (
      .req    (req),
      .last   (last),
      .winner (winner),
      .any    (any)
   );

`ifdef ROM_ARB_FIXED_PRIO_EN
   assign last = LAST_RST;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= LAST_RST;
      else if ((state != WAIT) && any)
         last <= winner;
   end
`endif

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      gnt_nxt      = '0;
      valid_nxt    = '0;
      rom_addr_nxt = rom_addr;
      rd_data_nxt  = rd_data;
      owner_nxt    = owner;
      case (state)
         IDLE, RESP: begin
            if (any) begin
               state_nxt       = WAIT;
               rom_addr_nxt    = (winner == REQ_B) ? addr_b : addr_a;
               gnt_nxt[winner] = 1'b1;
               cnt_nxt         = CW'(ROM_LAT);
               owner_nxt       = winner;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               rd_data_nxt      = rom_q;
               valid_nxt[owner] = 1'b1;
               state_nxt        = RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         gnt      <= '0;
         valid    <= '0;
         rom_addr <= '0;
         rd_data  <= '0;
         owner    <= REQ_A;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         gnt      <= gnt_nxt;
         valid    <= valid_nxt;
         rom_addr <= rom_addr_nxt;
         rd_data  <= rd_data_nxt;
         owner    <= owner_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule
